// File: rtl/scie_cfir_pipelined.sv
// scie_cfir_pipelined
//   Complex FIR accelerator driven by custom RISC-V instructions from the
//   core's SCIE port. It holds a TAPS-deep complex delay line and TAPS complex
//   coefficients. A PUSH shifts a sample into the delay line and starts a
//   two-stage computation: stage 1 registers the per-tap complex products, and
//   stage 2 sums them, scales them and writes result_reg. A READ returns the
//   latest completed result. If stage 2 completes on the same edge as the
//   READ, the READ returns the fresh value.
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   io_valid     instruction valid this cycle
//   io_insn      instruction word, opcode in [6:0]
//   io_rs1_real  signed real operand (coefficient or sample)
//   io_rs1_imag  signed imag operand (coefficient or sample)
//   io_rs2       tap index for LOAD_COEF
//   io_rd_real   registered result, real part
//   io_rd_imag   registered result, imag part
//   io_rd_valid  one-cycle pulse when io_rd_* is updated by a READ
//   io_busy      a PUSH is still in the pipeline
module scie_cfir_pipelined #(
    parameter int DATA_W    = 16,
    parameter int TAPS      = 5,
    parameter int FRAC_BITS = 0,
    parameter bit SAT       = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     io_valid,
    input  logic [31:0]              io_insn,
    input  logic signed [DATA_W-1:0] io_rs1_real,
    input  logic signed [DATA_W-1:0] io_rs1_imag,
    input  logic [31:0]              io_rs2,
    output logic signed [DATA_W-1:0] io_rd_real,
    output logic signed [DATA_W-1:0] io_rd_imag,
    output logic                     io_rd_valid,
    output logic                     io_busy
);

    localparam int PROD_W = 2 * DATA_W + 1;
    localparam int SUM_W  = PROD_W + $clog2(TAPS);

    localparam logic [6:0] OP_LOAD_COEF = 7'h0B;
    localparam logic [6:0] OP_PUSH      = 7'h2B;
    localparam logic [6:0] OP_READ      = 7'h5B;
    localparam logic [6:0] OP_CLEAR     = 7'h7B;

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    logic signed [DATA_W-1:0] coef_re [TAPS];
    logic signed [DATA_W-1:0] coef_im [TAPS];
    logic signed [DATA_W-1:0] x_re    [TAPS];
    logic signed [DATA_W-1:0] x_im    [TAPS];

    // launch: a PUSH was accepted on the last edge and the delay line now
    // holds its operands. The products are formed from that state on the
    // following edge.
    logic                     launch;
    logic                     s1_valid;
    logic signed [PROD_W-1:0] s1_re [TAPS];
    logic signed [PROD_W-1:0] s1_im [TAPS];

    logic signed [DATA_W-1:0] result_re;
    logic signed [DATA_W-1:0] result_im;

    logic dec_load;
    logic dec_push;
    logic dec_read;
    logic dec_clear;
    logic unused_insn;

    assign dec_load  = io_valid && (io_insn[6:0] == OP_LOAD_COEF);
    assign dec_push  = io_valid && (io_insn[6:0] == OP_PUSH);
    assign dec_read  = io_valid && (io_insn[6:0] == OP_READ);
    assign dec_clear = io_valid && (io_insn[6:0] == OP_CLEAR);
    assign unused_insn = ^io_insn[31:7];

    assign io_busy = launch | s1_valid;

    // Per-tap complex products, formed at full precision.
    logic signed [PROD_W-1:0] prod_re [TAPS];
    logic signed [PROD_W-1:0] prod_im [TAPS];

    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            prod_re[k] = PROD_W'(coef_re[k]) * PROD_W'(x_re[k])
                       - PROD_W'(coef_im[k]) * PROD_W'(x_im[k]);
            prod_im[k] = PROD_W'(coef_re[k]) * PROD_W'(x_im[k])
                       + PROD_W'(coef_im[k]) * PROD_W'(x_re[k]);
        end
    end

    // The adder tree has clog2(TAPS) guard bits, so the sum never overflows
    // before scaling.
    logic signed [SUM_W-1:0]  sum_re;
    logic signed [SUM_W-1:0]  sum_im;
    logic signed [SUM_W-1:0]  shf_re;
    logic signed [SUM_W-1:0]  shf_im;
    logic signed [DATA_W-1:0] fin_re;
    logic signed [DATA_W-1:0] fin_im;

    function automatic logic signed [DATA_W-1:0] fit(input logic signed [SUM_W-1:0] v);
        logic signed [DATA_W-1:0] r;
        r = v[DATA_W-1:0];
        if (SAT) begin
            if (v > SAT_MAX)
                r = SAT_MAX[DATA_W-1:0];
            else if (v < SAT_MIN)
                r = SAT_MIN[DATA_W-1:0];
        end
        return r;
    endfunction

    always_comb begin
        sum_re = '0;
        sum_im = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum_re = sum_re + SUM_W'(s1_re[k]);
            sum_im = sum_im + SUM_W'(s1_im[k]);
        end
        shf_re = sum_re >>> FRAC_BITS;
        shf_im = sum_im >>> FRAC_BITS;
        fin_re = fit(shf_re);
        fin_im = fit(shf_im);
    end

    // Coefficients and delay line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_re[k] <= '0;
                coef_im[k] <= '0;
                x_re[k]    <= '0;
                x_im[k]    <= '0;
            end
        end else begin
            if (dec_load) begin
                // An out-of-range index matches no tap and is silently dropped.
                for (int k = 0; k < TAPS; k++) begin
                    if (io_rs2 == 32'(k)) begin
                        coef_re[k] <= io_rs1_real;
                        coef_im[k] <= io_rs1_imag;
                    end
                end
            end
            if (dec_push) begin
                for (int k = TAPS - 1; k > 0; k--) begin
                    x_re[k] <= x_re[k-1];
                    x_im[k] <= x_im[k-1];
                end
                x_re[0] <= io_rs1_real;
                x_im[0] <= io_rs1_imag;
            end else if (dec_clear) begin
                for (int k = 0; k < TAPS; k++) begin
                    x_re[k] <= '0;
                    x_im[k] <= '0;
                end
            end
        end
    end

    // Pipeline and result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            launch      <= 1'b0;
            s1_valid    <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                s1_re[k] <= '0;
                s1_im[k] <= '0;
            end
            result_re   <= '0;
            result_im   <= '0;
            io_rd_real  <= '0;
            io_rd_imag  <= '0;
            io_rd_valid <= 1'b0;
        end else begin
            launch   <= dec_push;
            s1_valid <= launch;
            if (launch) begin
                for (int k = 0; k < TAPS; k++) begin
                    s1_re[k] <= prod_re[k];
                    s1_im[k] <= prod_im[k];
                end
            end
            if (s1_valid) begin
                result_re <= fin_re;
                result_im <= fin_im;
            end
            io_rd_valid <= dec_read;
            if (dec_read) begin
                // Forward the result that completes on this same edge.
                io_rd_real <= s1_valid ? fin_re : result_re;
                io_rd_imag <= s1_valid ? fin_im : result_im;
            end
        end
    end

endmodule

// File: tb/tb_scie_cfir_pipelined.sv
module tb_scie_cfir_pipelined;

    localparam int NT = 5;
    localparam logic [6:0] OP_LOAD  = 7'h0B;
    localparam logic [6:0] OP_PUSH  = 7'h2B;
    localparam logic [6:0] OP_READ  = 7'h5B;
    localparam logic [6:0] OP_CLEAR = 7'h7B;

    logic               clock   = 1'b0;
    logic               reset_n = 1'b1;
    logic               io_valid = 1'b0;
    logic [31:0]        io_insn  = '0;
    logic signed [15:0] rs1_re   = '0;
    logic signed [15:0] rs1_im   = '0;
    logic [31:0]        rs2      = '0;

    logic signed [15:0] rd_re0, rd_im0, rd_re1, rd_im1, rd_re2, rd_im2;
    logic               vld0, vld1, vld2, busy0, busy1, busy2;

    always #5 clock = ~clock;

    // d0: legacy wrap, d1: saturate, d2: saturate with Q15 scaling.
    scie_cfir_pipelined #(.DATA_W(16), .TAPS(NT), .FRAC_BITS(0), .SAT(1'b0)) u_d0 (
        .clock(clock), .reset_n(reset_n), .io_valid(io_valid), .io_insn(io_insn),
        .io_rs1_real(rs1_re), .io_rs1_imag(rs1_im), .io_rs2(rs2),
        .io_rd_real(rd_re0), .io_rd_imag(rd_im0), .io_rd_valid(vld0), .io_busy(busy0));
    scie_cfir_pipelined #(.DATA_W(16), .TAPS(NT), .FRAC_BITS(0), .SAT(1'b1)) u_d1 (
        .clock(clock), .reset_n(reset_n), .io_valid(io_valid), .io_insn(io_insn),
        .io_rs1_real(rs1_re), .io_rs1_imag(rs1_im), .io_rs2(rs2),
        .io_rd_real(rd_re1), .io_rd_imag(rd_im1), .io_rd_valid(vld1), .io_busy(busy1));
    scie_cfir_pipelined #(.DATA_W(16), .TAPS(NT), .FRAC_BITS(15), .SAT(1'b1)) u_d2 (
        .clock(clock), .reset_n(reset_n), .io_valid(io_valid), .io_insn(io_insn),
        .io_rs1_real(rs1_re), .io_rs1_imag(rs1_im), .io_rs2(rs2),
        .io_rd_real(rd_re2), .io_rd_imag(rd_im2), .io_rd_valid(vld2), .io_busy(busy2));

    int n_cmp = 0;
    int n_bad = 0;
    int edge_cnt = 0;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint re;
        longint im;
        int     done;
    } pend_t;

    typedef struct {
        int     at;
        longint re0, im0, re1, im1, re2, im2;
    } exp_t;

    longint m_cr [NT];
    longint m_ci [NT];
    longint m_xr [NT];
    longint m_xi [NT];
    pend_t  pend [$];
    exp_t   eq   [$];
    bit     push_at [int];
    longint last_re, last_im;

    function automatic longint fin(input longint s, input int frac, input bit sat);
        longint v;
        logic [15:0] lo;
        v = s >>> frac;
        if (sat) begin
            if (v > 32767) v = 32767;
            else if (v < -32768) v = -32768;
            return v;
        end
        lo = v[15:0];
        return longint'($signed(lo));
    endfunction

    function automatic longint rnd16();
        logic [15:0] u;
        u = 16'($urandom());
        return longint'($signed(u));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NT; k++) begin
            m_cr[k] = 0; m_ci[k] = 0; m_xr[k] = 0; m_xi[k] = 0;
        end
        pend.delete();
        eq.delete();
        push_at.delete();
        last_re = 0;
        last_im = 0;
    endtask

    // Drive one instruction on the next negedge; it is sampled on the
    // following posedge, whose index is edge_cnt at drive time.
    task automatic drive(input bit vld, input logic [6:0] op, input longint re,
                         input longint im, input int unsigned idx);
        int     e;
        longint sr, si;
        pend_t  p;
        exp_t   x;
        @(negedge clock);
        e = edge_cnt;
        io_valid = vld;
        io_insn  = {25'($urandom()), op};
        rs1_re   = 16'(re);
        rs1_im   = 16'(im);
        rs2      = idx;
        if (!vld) return;
        case (op)
            OP_LOAD: begin
                if (idx < NT) begin
                    m_cr[idx] = re;
                    m_ci[idx] = im;
                end
            end
            OP_PUSH: begin
                for (int k = NT - 1; k > 0; k--) begin
                    m_xr[k] = m_xr[k-1];
                    m_xi[k] = m_xi[k-1];
                end
                m_xr[0] = re;
                m_xi[0] = im;
                sr = 0;
                si = 0;
                for (int k = 0; k < NT; k++) begin
                    sr += m_cr[k] * m_xr[k] - m_ci[k] * m_xi[k];
                    si += m_cr[k] * m_xi[k] + m_ci[k] * m_xr[k];
                end
                p.re = sr; p.im = si; p.done = e + 2;
                pend.push_back(p);
                push_at[e] = 1'b1;
            end
            OP_READ: begin
                while (pend.size() > 0 && pend[0].done <= e) begin
                    p = pend.pop_front();
                    last_re = p.re;
                    last_im = p.im;
                end
                x.at  = e;
                x.re0 = fin(last_re, 0, 1'b0);  x.im0 = fin(last_im, 0, 1'b0);
                x.re1 = fin(last_re, 0, 1'b1);  x.im1 = fin(last_im, 0, 1'b1);
                x.re2 = fin(last_re, 15, 1'b1); x.im2 = fin(last_im, 15, 1'b1);
                eq.push_back(x);
            end
            OP_CLEAR: begin
                for (int k = 0; k < NT; k++) begin
                    m_xr[k] = 0;
                    m_xi[k] = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic idle();
        drive(1'b0, 7'h00, 0, 0, 0);
    endtask

    task automatic push_read(input longint re, input longint im);
        drive(1'b1, OP_PUSH, re, im, 0);
        idle();
        drive(1'b1, OP_READ, 0, 0, 0);
        idle();
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   mon_e;
    bit   mon_ev;
    exp_t mon_x;

    always @(posedge clock) begin
        #1;
        if (reset_n) begin
            mon_e  = edge_cnt - 1;
            mon_ev = (eq.size() > 0) && (eq[0].at == mon_e);
            chk("rd_valid_d0", vld0, mon_ev);
            chk("rd_valid_d1", vld1, mon_ev);
            chk("rd_valid_d2", vld2, mon_ev);
            chk("busy_d0", busy0, push_at.exists(mon_e) || push_at.exists(mon_e - 1));
            chk("busy_d2", busy2, push_at.exists(mon_e) || push_at.exists(mon_e - 1));
            if (mon_ev) begin
                mon_x = eq.pop_front();
                chk("rd_real_d0", rd_re0, mon_x.re0);
                chk("rd_imag_d0", rd_im0, mon_x.im0);
                chk("rd_real_d1", rd_re1, mon_x.re1);
                chk("rd_imag_d1", rd_im1, mon_x.im1);
                chk("rd_real_d2", rd_re2, mon_x.re2);
                chk("rd_imag_d2", rd_im2, mon_x.im2);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [6:0] all_ops [4];
    logic [6:0] bogus   [4];
    int r;

    initial begin
        all_ops = '{OP_LOAD, OP_PUSH, OP_READ, OP_CLEAR};
        bogus   = '{7'h13, 7'h33, 7'h0F, 7'h2A};
        model_reset();

        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_rd_real", rd_re0, 0);
        chk("reset_rd_imag", rd_im0, 0);
        chk("reset_rd_valid", vld0, 0);
        chk("reset_busy", busy0, 0);
        chk("reset_rd_real_d2", rd_re2, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Legacy coefficient set, wrap mode.
        drive(1'b1, OP_LOAD, -46,   5, 0);
        drive(1'b1, OP_LOAD,  14,  17, 1);
        drive(1'b1, OP_LOAD, -38,  25, 2);
        drive(1'b1, OP_LOAD,  -2, -27, 3);
        drive(1'b1, OP_LOAD,  44,   1, 4);

        push_read(12, 0);
        chk("t1_real", rd_re0, -552);
        chk("t1_imag", rd_im0, 60);
        push_read(11, 28);
        chk("t2_real", rd_re0, -478);
        chk("t2_imag", rd_im0, -1029);
        push_read(17, 24);
        chk("t3_real", rd_re0, -1680);
        chk("t3_imag", rd_im0, -140);

        // READ one cycle after PUSH sees the old result; two cycles after, the forwarded one.
        drive(1'b1, OP_PUSH, 1, 0, 0);
        drive(1'b1, OP_READ, 0, 0, 0);
        chk("busy_inflight", busy0, 1);
        drive(1'b1, OP_READ, 0, 0, 0);
        chk("early_read_real", rd_re0, -1680);
        chk("early_read_imag", rd_im0, -140);
        idle();
        chk("fwd_read_real", rd_re0, -1358);
        chk("fwd_read_imag", rd_im0, -483);

        // CLEAR leaves only tap 0 contributing; out-of-range LOAD_COEF is ignored.
        drive(1'b1, OP_CLEAR, 0, 0, 0);
        push_read(12, 0);
        chk("clear_real", rd_re0, -552);
        chk("clear_imag", rd_im0, 60);
        drive(1'b1, OP_CLEAR, 0, 0, 0);
        drive(1'b1, OP_LOAD, 1000, -1000, 7);
        push_read(12, 0);
        chk("oob_load_real", rd_re0, -552);
        chk("oob_load_imag", rd_im0, 60);

        // Saturation and scaling boundaries.
        drive(1'b1, OP_CLEAR, 0, 0, 0);
        drive(1'b1, OP_LOAD, 32767, 0, 0);
        push_read(32767, 0);
        chk("wrap_max_d0", rd_re0, 1);
        chk("sat_max_d1", rd_re1, 32767);
        chk("sat_max_imag_d1", rd_im1, 0);
        chk("q15_max_d2", rd_re2, 32766);
        drive(1'b1, OP_CLEAR, 0, 0, 0);
        drive(1'b1, OP_LOAD, -32768, 0, 0);
        push_read(32767, 0);
        chk("wrap_min_d0", rd_re0, -32768);
        chk("sat_min_d1", rd_re1, -32768);
        chk("q15_min_d2", rd_re2, -32767);

        // Reset while a PUSH is in flight.
        drive(1'b1, OP_LOAD, 100, 100, 1);
        drive(1'b1, OP_PUSH, 5, 5, 0);
        @(negedge clock);
        reset_n  = 1'b0;
        io_valid = 1'b0;
        #1;
        chk("midreset_rd_real", rd_re0, 0);
        chk("midreset_busy", busy0, 0);
        chk("midreset_rd_real_d1", rd_re1, 0);
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        drive(1'b1, OP_READ, 0, 0, 0);
        idle();
        chk("post_reset_read_real", rd_re0, 0);
        chk("post_reset_read_imag", rd_im0, 0);
        push_read(1, 0);
        chk("post_reset_coef_real", rd_re0, 0);
        chk("post_reset_coef_imag", rd_im0, 0);

        // Randomized traffic, including back-to-back PUSHes and reads during busy.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 20)
                drive(1'b1, OP_LOAD, rnd16(), rnd16(), $urandom_range(0, 7));
            else if (r < 50)
                drive(1'b1, OP_PUSH, rnd16(), rnd16(), $urandom());
            else if (r < 72)
                drive(1'b1, OP_READ, rnd16(), rnd16(), $urandom());
            else if (r < 77)
                drive(1'b1, OP_CLEAR, rnd16(), rnd16(), $urandom());
            else if (r < 90)
                drive(1'b0, all_ops[$urandom_range(0, 3)], rnd16(), rnd16(), $urandom_range(0, 4));
            else
                drive(1'b1, bogus[$urandom_range(0, 3)], rnd16(), rnd16(), $urandom_range(0, 4));
        end
        drive(1'b1, OP_READ, 0, 0, 0);
        repeat (4) idle();
        chk("pending_reads", eq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
